axis_frame_capture: RTL and testbench
=====================================

# axis_frame_capture

Sink for the `axis_rfdc` complex-sample stream: the receiving end of the sample/impulse generators.
- Aligns to frame boundaries using `tlast` and captures one full FFT_LEN-sample frame into an internal buffer on request.
- Flags any `tlast` placement that disagrees with FFT_LEN.
- Exposes the captured frame through a registered read port.
- Serves as the bench-side and on-chip capture point for checking generator and PFB front-end output.

## Interface
- FFT_LEN, 16, samples per frame; power of two, multiple of SAMP_PER_CLK.
- WIDTH / SAMP_PER_CLK are taken from the connected `axis_rfdc` interface, not from module parameters.
- clk  in  1  sole clock; everything is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_axis  axis_rfdc.SLV  —  stream input: tdata (SAMP_PER_CLK × {im,re}, sample 0 in the LSBs), tvalid, tlast in; tready out.
- arm  in  1  single-cycle request to capture the next complete frame.
- rd_addr  in  $clog2(FFT_LEN)  sample index to read.
- rd_data  out  2*WIDTH  captured sample {im,re}.
- done  out  1  a frame has been captured; held until the next arm or rst.
- err_tlast  out  1  sticky tlast-misalignment flag.
- frame_cnt  out  32  count of accepted beats carrying tlast.

## Operation
- A beat is accepted when `tvalid & tready`.
- tready = ~rst. The block never back-pressures outside reset; frames arriving in IDLE or DONE are consumed and discarded.
- wAddr is the sample write pointer, $clog2(FFT_LEN) bits, stepping by SAMP_PER_CLK per accepted beat.
- Each beat writes buf[wAddr + k] = tdata[k] for k = 0..SAMP_PER_CLK-1.
- FSM states: IDLE, SYNC, CAPTURE, DONE.
  - IDLE: arm → SYNC.
  - SYNC: accepted beats are discarded. An accepted beat with tlast → CAPTURE with wAddr = 0, so capture starts on the beat after a boundary.
  - CAPTURE: every accepted beat is written, then wAddr += SAMP_PER_CLK.
    - Beat at wAddr = FFT_LEN-SAMP_PER_CLK: go to DONE whether or not tlast is present. If tlast is absent, set err_tlast.
    - Beat with tlast at any other wAddr (early tlast): set err_tlast, set wAddr = 0, stay in CAPTURE (realign). Data already written is overwritten by the new frame.
  - DONE: done = 1. arm → SYNC.
- arm in SYNC or CAPTURE restarts the sequence: → SYNC, wAddr = 0, done and err_tlast cleared.
- arm on the same cycle as a completing beat: arm wins. State goes to SYNC, done stays 0; the beat's data is still written.
- arm always clears err_tlast. A same-cycle error is dropped, because arm has priority.
- frame_cnt increments on every accepted tlast beat in every state, wrapping at 2^32.
- rd_data = buf[rd_addr], registered. It is valid in any state, but contents are only meaningful while done = 1.

## Timing
- Reset values: tready 0 during rst; state IDLE, wAddr 0, done 0, err_tlast 0, frame_cnt 0, rd_data 0. Buffer contents are not reset.
- rst asserted mid-capture: on the next edge all of the above values apply; any partial frame is abandoned.
- done rises on the edge that accepts the final beat. It is visible the following cycle.
- err_tlast sets on the edge of the offending beat.
- Read latency is 1 cycle: rd_addr presented at edge N gives rd_data after edge N+1.
- A read in the cycle after done rises returns the final beat's data (write happens before the registered read).
- Capture latency from arm is: remainder of the current frame + one full frame, i.e. at most 2·FFT_LEN/SAMP_PER_CLK accepted beats.
- tvalid deasserted in any state: no state change. Gaps are allowed at any beat.

## Test plan
- **Ramp capture.** Drive with impulse_generator (FFT_LEN=16, SAMP_PER_CLK=4, ram re=i, im=0) streaming continuously; pulse arm mid-frame.
  - done rises within 8 beats.
  - Reading rd_addr 0..15 returns re = 0..15, im = 0.
  - err_tlast = 0.
- **Early tlast.** Beats of 4 samples with tlast on the 2nd beat of a frame during CAPTURE.
  - err_tlast = 1; wAddr realigns.
  - The following clean 4-beat frame (re 100..115) captures; done = 1; buf = 100..115.
- **Missing tlast.** 4th beat of a frame has tlast = 0.
  - done = 1, err_tlast = 1.
  - frame_cnt does not increment on that beat.
- **Throttled input.** tvalid is a random 50 % duty pattern; tready stays 1.
  - The captured frame equals the ramp.
  - frame_cnt equals the number of tlast beats driven.
- **Re-arm / collision.** arm pulsed in DONE → SYNC, done = 0, err_tlast = 0. arm on the same edge as the completing beat → state SYNC, done stays 0.
- **Reset mid-capture.** rst asserted after 2 captured beats.
  - Next cycle: tready 0, done 0, frame_cnt 0, rd_data 0.
  - After release, arm captures normally.

Source files
------------

// File: rtl/axis_frame_capture_if.sv
// Complex-sample stream: SAMP_PER_CLK samples per beat, each sample {im,re} of WIDTH bits,
// sample 0 in the least significant bits of tdata.
interface axis_rfdc #(
  parameter int WIDTH        = 16,
  parameter int SAMP_PER_CLK = 4
);
  logic [SAMP_PER_CLK*2*WIDTH-1:0] tdata;
  logic                            tvalid;
  logic                            tlast;
  logic                            tready;

  modport MST (output tdata, output tvalid, output tlast, input tready);
  modport SLV (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_capture.sv
// Frame-aligned capture sink for the axis_rfdc sample stream: on arm, waits for a tlast
// boundary, stores the next full frame, and exposes it through a registered read port.
module axis_frame_capture #(
  parameter int FFT_LEN = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  axis_rfdc.SLV                        s_axis,
  input  logic                         arm,
  input  logic [$clog2(FFT_LEN)-1:0]   rd_addr,
  output logic [2*s_axis.WIDTH-1:0]    rd_data,
  output logic                         done,
  output logic                         err_tlast,
  output logic [31:0]                  frame_cnt
);
  localparam int WIDTH = s_axis.WIDTH;
  localparam int SPC   = s_axis.SAMP_PER_CLK;
  localparam int AW    = $clog2(FFT_LEN);
  localparam int SW    = 2 * WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(FFT_LEN - SPC);
  localparam logic [AW-1:0] STEP      = AW'(SPC);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] w_addr, w_addr_n;
  logic          done_n, err_n;
  logic          wr_en;
  logic          accept;
  logic [SW-1:0] mem [FFT_LEN];

  assign s_axis.tready = ~rst;
  assign accept        = s_axis.tvalid & s_axis.tready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      w_addr    <= '0;
      done      <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      state     <= state_n;
      w_addr    <= w_addr_n;
      done      <= done_n;
      err_tlast <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    w_addr_n = w_addr;
    done_n   = done;
    err_n    = err_tlast;
    wr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_n = SYNC;
      end
      SYNC: begin
        if (accept && s_axis.tlast) begin
          state_n  = CAPTURE;
          w_addr_n = '0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_en = 1'b1;
          if (w_addr == LAST_ADDR) begin
            state_n  = DONE;
            done_n   = 1'b1;
            w_addr_n = '0;
            if (!s_axis.tlast) err_n = 1'b1;
          end else if (s_axis.tlast) begin
            // Early boundary: restart the frame so the next beat lands at sample 0
            err_n    = 1'b1;
            w_addr_n = '0;
          end else begin
            w_addr_n = w_addr + STEP;
          end
        end
      end
      DONE: begin
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
    // arm overrides whatever the current beat decided, but the beat's write still happens
    if (arm) begin
      state_n  = SYNC;
      w_addr_n = '0;
      done_n   = 1'b0;
      err_n    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < SPC; k++) begin
        mem[w_addr + AW'(k)] <= s_axis.tdata[k*SW +: SW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst)                         frame_cnt <= '0;
    else if (accept && s_axis.tlast) frame_cnt <= frame_cnt + 32'd1;
  end
endmodule

// File: tb/tb_axis_frame_capture.sv
// Randomised scoreboard bench for axis_frame_capture: stimulus tasks push expectations
// computed from a beat-log reference model; a negedge monitor pops and compares.
module tb_axis_frame_capture;
  localparam int FFT_LEN = 16;
  localparam int SPC     = 4;
  localparam int WIDTH   = 16;
  localparam int BEATS   = FFT_LEN / SPC;

  localparam logic [2:0] K_DONE  = 3'd0;
  localparam logic [2:0] K_ERR   = 3'd1;
  localparam logic [2:0] K_CNT   = 3'd2;
  localparam logic [2:0] K_READY = 3'd3;
  localparam logic [2:0] K_RDATA = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic        done;
  logic        err_tlast;
  logic [31:0] frame_cnt;

  axis_rfdc #(.WIDTH(WIDTH), .SAMP_PER_CLK(SPC)) s_axis ();

  axis_frame_capture #(.FFT_LEN(FFT_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axis    (s_axis),
    .arm       (arm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .done      (done),
    .err_tlast (err_tlast),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] val;
  } exp_t;

  typedef struct packed {
    logic [SPC*32-1:0] data;
    logic              last;
  } beat_t;

  exp_t        st_q[$];
  exp_t        rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        st_strobe = 1'b0;
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;
  string       cur_tag = "none";

  // Reference model: every beat accepted since the last arm, replayed at check time
  beat_t       log_q[$];
  bit          armed = 1'b0;
  int unsigned tlast_total = 0;
  logic [31:0] m_buf [FFT_LEN];
  bit          m_done;
  bit          m_err;

  always @(posedge clk) rd_pend <= rd_req;

  function automatic logic [31:0] observe(input logic [2:0] k);
    case (k)
      K_DONE:  return {31'd0, done};
      K_ERR:   return {31'd0, err_tlast};
      K_CNT:   return frame_cnt;
      K_READY: return {31'd0, s_axis.tready};
      default: return rd_data;
    endcase
  endfunction

  function automatic string kind_name(input logic [2:0] k);
    case (k)
      K_DONE:  return "done";
      K_ERR:   return "err_tlast";
      K_CNT:   return "frame_cnt";
      K_READY: return "tready";
      default: return "rd_data";
    endcase
  endfunction

  function automatic void compare(input exp_t e);
    logic [31:0] act;
    act = observe(e.kind);
    checks++;
    if (act !== e.val) begin
      errors++;
      $display("[TB] FAIL %s/%s: got 0x%08h expected 0x%08h", cur_tag, kind_name(e.kind), act, e.val);
    end
  endfunction

  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s/rd_queue: got empty queue expected an entry", cur_tag);
      end else begin
        compare(rd_q.pop_front());
      end
    end
    if (st_strobe) begin
      while (st_q.size() > 0) compare(st_q.pop_front());
    end
  end

  function automatic void model_eval();
    bit synced;
    int pos;
    synced = 1'b0;
    pos    = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (!armed) return;
    for (int i = 0; i < log_q.size(); i++) begin
      if (m_done) break;
      if (!synced) begin
        synced = log_q[i].last;
        continue;
      end
      for (int k = 0; k < SPC; k++) m_buf[pos + k] = log_q[i].data[k*32 +: 32];
      if (pos + SPC == FFT_LEN) begin
        m_done = 1'b1;
        if (!log_q[i].last) m_err = 1'b1;
      end else if (log_q[i].last) begin
        m_err = 1'b1;
        pos   = 0;
      end else begin
        pos = pos + SPC;
      end
    end
  endfunction

  function automatic logic [31:0] sample(input int idx, input bit imflag);
    logic [15:0] re;
    logic [15:0] im;
    re = 16'(idx);
    im = imflag ? (re ^ 16'hA5A5) : 16'h0000;
    return {im, re};
  endfunction

  // One beat starting at sample index 'base', preceded by up to max_gap random idle cycles
  task automatic applyStimulus(input int base, input bit last, input int max_gap,
                               input bit with_arm, input bit imflag);
    logic [SPC*32-1:0] data;
    beat_t             b;
    int                g;
    g = 0;
    while (g < max_gap && $urandom_range(0, 1) == 1) begin
      s_axis.tvalid = 1'b0;
      @(posedge clk); #1;
      g++;
    end
    for (int k = 0; k < SPC; k++) data[k*32 +: 32] = sample(base + k, imflag);
    s_axis.tdata  = data;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    arm           = with_arm;
    if (last) tlast_total++;
    if (with_arm) begin
      log_q.delete();
      armed = 1'b1;
    end else if (armed) begin
      b.data = data;
      b.last = last;
      log_q.push_back(b);
    end
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    arm           = 1'b0;
  endtask

  task automatic sendFrame(input int base, input int max_gap, input bit imflag);
    for (int b = 0; b < BEATS; b++)
      applyStimulus(base + b*SPC, (b == BEATS-1), max_gap, 1'b0, imflag);
  endtask

  task automatic pulseArm();
    arm = 1'b1;
    log_q.delete();
    armed = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input bit with_rdata);
    exp_t e;
    model_eval();
    e.kind = K_DONE;  e.val = {31'd0, m_done};      st_q.push_back(e);
    e.kind = K_ERR;   e.val = {31'd0, m_err};       st_q.push_back(e);
    e.kind = K_CNT;   e.val = tlast_total;          st_q.push_back(e);
    e.kind = K_READY; e.val = {31'd0, ~rst};        st_q.push_back(e);
    if (with_rdata) begin
      e.kind = K_RDATA; e.val = 32'd0; st_q.push_back(e);
    end
    cur_tag   = tag;
    st_strobe = 1'b1;
    @(posedge clk); #1;
    st_strobe = 1'b0;
  endtask

  task automatic readFrame(input string tag);
    exp_t e;
    model_eval();
    cur_tag = tag;
    for (int i = 0; i < FFT_LEN; i++) begin
      rd_addr = 4'(i);
      e.kind  = K_RDATA;
      e.val   = m_buf[i];
      rd_q.push_back(e);
      rd_req = 1'b1;
      @(posedge clk); #1;
    end
    rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    arm           = 1'b0;
    rd_addr       = '0;
    s_axis.tdata  = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp capture with arm half-way through a frame
    applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);
    pulseArm();
    applyStimulus(8, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(12, 1'b1, 0, 1'b0, 1'b0);
    sendFrame(0, 0, 1'b0);
    checkOutput("ramp_done", 1'b0);
    applyStimulus(0, 1'b0, 0, 1'b0, 1'b0);
    applyStimulus(4, 1'b0, 0, 1'b0, 1'b0);
    readFrame("ramp_read");

    // Early tlast on the second beat, then a clean frame
    pulseArm();
    sendFrame(0, 0, 1'b0);
    applyStimulus(50, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(54, 1'b1, 0, 1'b0, 1'b1);
    checkOutput("early_err", 1'b0);
    sendFrame(100, 0, 1'b1);
    checkOutput("early_done", 1'b0);
    readFrame("early_read");

    // Missing tlast on the fourth beat
    pulseArm();
    sendFrame(200, 0, 1'b1);
    for (int b = 0; b < BEATS; b++) applyStimulus(300 + b*SPC, 1'b0, 0, 1'b0, 1'b1);
    checkOutput("missing", 1'b0);
    readFrame("missing_read");

    // Re-arm in DONE clears done and err
    pulseArm();
    checkOutput("rearm", 1'b0);

    // arm colliding with the completing beat
    sendFrame(350, 0, 1'b1);
    for (int b = 0; b < BEATS-1; b++) applyStimulus(360 + b*SPC, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(372, 1'b1, 0, 1'b1, 1'b1);
    checkOutput("collide", 1'b0);
    sendFrame(400, 0, 1'b1);
    checkOutput("collide_sync", 1'b0);
    sendFrame(500, 0, 1'b1);
    checkOutput("collide_done", 1'b0);
    readFrame("collide_read");

    // Throttled input with random idle cycles between beats
    pulseArm();
    for (int f = 0; f < 3; f++) sendFrame(0, 6, 1'b0);
    checkOutput("throttle", 1'b0);
    readFrame("throttle_read");

    // Reset in the middle of a capture
    pulseArm();
    sendFrame(600, 0, 1'b1);
    applyStimulus(640, 1'b0, 0, 1'b0, 1'b1);
    applyStimulus(644, 1'b0, 0, 1'b0, 1'b1);
    rst = 1'b1;
    log_q.delete();
    armed       = 1'b0;
    tlast_total = 0;
    @(posedge clk); #1;
    checkOutput("rst_mid", 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    pulseArm();
    sendFrame(700, 2, 1'b1);
    sendFrame(720, 2, 1'b1);
    checkOutput("post_rst", 1'b0);
    readFrame("post_rst_read");

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (st_q.size() + rd_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", st_q.size() + rd_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
